// File: rtl/sys_cmd_ctrl_if.sv
// Signal bundle between the command sequencer and its UART RX, register file,
// ALU and TX FIFO neighbours. The master modport is the sequencer's view.
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_valid;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_valid;
  logic                    fifo_full;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic                    alu_en;
  logic [3:0]              alu_fun;
  logic                    clk_gate_en;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_wr_en;
  logic                    cmd_err;

  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, fifo_full,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
           tx_data, tx_wr_en, cmd_err
  );

  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, fifo_full,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
           tx_data, tx_wr_en, cmd_err
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes the UART byte protocol (write, read, ALU with and
// without operands) and drives register file, ALU, ALU clock gate and TX FIFO.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic             clk,
  input logic             reset,
  sys_cmd_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD,
    OP_A, OP_B, FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_FUN = DATA_WIDTH'(8'hDD);

  state_t state, state_nx;

  logic                    rf_wr_en_q, rf_wr_en_nx;
  logic                    rf_rd_en_q, rf_rd_en_nx;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_nx;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_nx;
  logic                    alu_en_q, alu_en_nx;
  logic [3:0]              alu_fun_q, alu_fun_nx;
  logic                    clk_gate_en_q, clk_gate_en_nx;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_nx;
  logic                    tx_wr_en_q, tx_wr_en_nx;
  logic                    cmd_err_q, cmd_err_nx;

  logic [2*DATA_WIDTH-1:0] hold;
  logic                    hold_ld_rd;
  logic                    hold_ld_alu;

  // Opcode byte to first collecting state; IDLE marks an unknown command.
  function automatic state_t decode_opcode(input logic [DATA_WIDTH-1:0] b);
    state_t s;
    s = IDLE;
    if (b == OPC_WR)       s = WR_ADDR;
    else if (b == OPC_RD)  s = RD_ADDR;
    else if (b == OPC_ALU) s = OP_A;
    else if (b == OPC_FUN) s = FUN;
    return s;
  endfunction

  always_comb begin
    state_nx       = state;
    rf_wr_en_nx    = 1'b0;
    rf_rd_en_nx    = 1'b0;
    alu_en_nx      = 1'b0;
    tx_wr_en_nx    = 1'b0;
    cmd_err_nx     = 1'b0;
    rf_addr_nx     = rf_addr_q;
    rf_wr_data_nx  = rf_wr_data_q;
    alu_fun_nx     = alu_fun_q;
    clk_gate_en_nx = clk_gate_en_q;
    tx_data_nx     = tx_data_q;
    hold_ld_rd     = 1'b0;
    hold_ld_alu    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          state_nx   = decode_opcode(bus.rx_data);
          cmd_err_nx = (decode_opcode(bus.rx_data) == IDLE);
        end
      end
      WR_ADDR: begin
        if (bus.rx_valid) begin
          rf_addr_nx = bus.rx_data[ADDR_WIDTH-1:0];
          state_nx   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.rx_valid) begin
          rf_wr_data_nx = bus.rx_data;
          rf_wr_en_nx   = 1'b1;
          state_nx      = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.rx_valid) begin
          rf_addr_nx  = bus.rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_nx = 1'b1;
          state_nx    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Push straight through when the FIFO has room so the byte leaves one
        // cycle after rf_rd_valid; otherwise park it for TX_RD.
        if (bus.rf_rd_valid) begin
          if (!bus.fifo_full) begin
            tx_data_nx  = bus.rf_rd_data;
            tx_wr_en_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            hold_ld_rd = 1'b1;
            state_nx   = TX_RD;
          end
        end
      end
      TX_RD: begin
        if (!bus.fifo_full) begin
          tx_data_nx  = hold[DATA_WIDTH-1:0];
          tx_wr_en_nx = 1'b1;
          state_nx    = IDLE;
        end
      end
      OP_A: begin
        if (bus.rx_valid) begin
          rf_addr_nx    = ADDR_WIDTH'(0);
          rf_wr_data_nx = bus.rx_data;
          rf_wr_en_nx   = 1'b1;
          state_nx      = OP_B;
        end
      end
      OP_B: begin
        if (bus.rx_valid) begin
          rf_addr_nx    = ADDR_WIDTH'(1);
          rf_wr_data_nx = bus.rx_data;
          rf_wr_en_nx   = 1'b1;
          state_nx      = FUN;
        end
      end
      FUN: begin
        if (bus.rx_valid) begin
          alu_fun_nx     = bus.rx_data[3:0];
          alu_en_nx      = 1'b1;
          clk_gate_en_nx = 1'b1;
          state_nx       = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        // The ALU clock stays ungated until its result is captured.
        if (bus.alu_valid) begin
          hold_ld_alu    = 1'b1;
          clk_gate_en_nx = 1'b0;
          state_nx       = TX_LO;
        end
      end
      TX_LO: begin
        if (!bus.fifo_full) begin
          tx_data_nx  = hold[DATA_WIDTH-1:0];
          tx_wr_en_nx = 1'b1;
          state_nx    = TX_HI;
        end
      end
      TX_HI: begin
        if (!bus.fifo_full) begin
          tx_data_nx  = hold[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_wr_en_nx = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_data_q     <= '0;
      tx_wr_en_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state         <= state_nx;
      rf_wr_en_q    <= rf_wr_en_nx;
      rf_rd_en_q    <= rf_rd_en_nx;
      rf_addr_q     <= rf_addr_nx;
      rf_wr_data_q  <= rf_wr_data_nx;
      alu_en_q      <= alu_en_nx;
      alu_fun_q     <= alu_fun_nx;
      clk_gate_en_q <= clk_gate_en_nx;
      tx_data_q     <= tx_data_nx;
      tx_wr_en_q    <= tx_wr_en_nx;
      cmd_err_q     <= cmd_err_nx;
    end
  end

  // Response holding register is pure data; its contents only matter after a load.
  always_ff @(posedge clk) begin
    if (hold_ld_alu)
      hold <= bus.alu_out;
    else if (hold_ld_rd)
      hold <= {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
  end

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_wr_en    = tx_wr_en_q;
  assign bus.cmd_err     = cmd_err_q;

endmodule
